// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// instruction format codes and J-type condition codes.
// Optional feature macro: SEQ_WATCHDOG_EN (adds the FAULT state).
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
`ifdef SEQ_WATCHDOG_EN
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
`else
    ST_HALTED = 3'd4
`endif
  } seq_state_e;

  localparam logic [1:0] FMT_R  = 2'b00;
  localparam logic [1:0] FMT_I  = 2'b01;
  localparam logic [1:0] FMT_J  = 2'b10;
  localparam logic [1:0] FMT_LS = 2'b11;

  localparam logic [2:0] JC_JMP  = 3'b000;
  localparam logic [2:0] JC_JZ   = 3'b001;
  localparam logic [2:0] JC_JNZ  = 3'b010;
  localparam logic [2:0] JC_HALT = 3'b111;

  // J-type words are consumed by the sequencer and never reach control_unit.
  function automatic logic is_jtype(input logic [15:0] word);
    return word[1:0] == FMT_J;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Run-length watchdog: a down-counter loaded on entry to EXEC; expired is
// raised on the cycle the count reaches terminal count while still in EXEC.
// Only instantiated when SEQ_WATCHDOG_EN is defined.
module seq_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic active,
  output logic expired
);

  // Loading LIMIT-1 makes expiry land on the LIMIT-th EXEC cycle.
  localparam logic [3:0] TC_LOAD = 4'(LIMIT - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: reload on EXEC entry, count down while in EXEC, hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TC_LOAD;
    end else if (active && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = active && (cnt_q == 4'd0);

endmodule

// File: rtl/instruction_sequencer.sv
// Program sequencer in front of control_unit: owns the PC, fetches from a
// synchronous ROM, executes J-type jumps/halt locally and hands every other
// instruction to control_unit via one registered run window.
// Optional feature macro: SEQ_WATCHDOG_EN (run-length watchdog + FAULT).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset; pc and retired held at 0, waiting for start
// FETCH  | ROM read strobe issued for address pc
// DECODE | ROM word valid; latch it, resolve J-type or go to EXEC
// EXEC   | run high, waiting for done2 from control_unit
// HALTED | HALT executed; start restarts from address 0
// FAULT  | watchdog expired; only reset leaves (watchdog builds only)
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WDOG_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  zero,
  input  logic                  done2,
  output logic                  imem_rd_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [15:0]           imem_rdata,
  output logic [15:0]           instruction,
  output logic                  run,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic [15:0]           retired,
  output logic                  fault
);

  if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 16)) begin : g_bad_addr_width
    $error("instruction_sequencer: ADDR_WIDTH must be 1..16");
  end
  if ((WDOG_LIMIT < 1) || (WDOG_LIMIT > 15)) begin : g_bad_wdog_limit
    $error("instruction_sequencer: WDOG_LIMIT must be 1..15");
  end

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           instr_q, instr_d;
  logic [15:0]           retired_q, retired_d;
  logic                  run_q, run_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [15:0]           retired_inc;
  logic                  wdog_expired;

  assign pc_inc      = pc_q + ADDR_WIDTH'(1);
  assign jump_target = ADDR_WIDTH'(imem_rdata[15:8]);
  assign retired_inc = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

`ifdef SEQ_WATCHDOG_EN
  logic wdog_load;
  logic wdog_active;

  assign wdog_load   = (state_q != ST_EXEC) && (state_d == ST_EXEC);
  assign wdog_active = (state_q == ST_EXEC);

  seq_watchdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .load    (wdog_load),
    .active  (wdog_active),
    .expired (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  // Next-state, PC, instruction latch and retire-count logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;

    unique case (state_q)
      ST_IDLE: begin
        pc_d      = '0;
        retired_d = '0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        instr_d = imem_rdata;
        if (!is_jtype(imem_rdata)) begin
          state_d = ST_EXEC;
        end else begin
          retired_d = retired_inc;
          state_d   = ST_FETCH;
          unique case (imem_rdata[4:2])
            JC_JMP:  pc_d = jump_target;
            JC_JZ:   pc_d = zero ? jump_target : pc_inc;
            JC_JNZ:  pc_d = zero ? pc_inc : jump_target;
            JC_HALT: state_d = ST_HALTED;
            default: pc_d = pc_inc;
          endcase
        end
      end
      ST_EXEC: begin
        // done2 wins over a watchdog expiry landing on the same cycle.
        if (done2) begin
          pc_d      = pc_inc;
          retired_d = retired_inc;
          state_d   = ST_FETCH;
        end else if (wdog_expired) begin
`ifdef SEQ_WATCHDOG_EN
          state_d = ST_FAULT;
`endif
        end
      end
      ST_HALTED: begin
        if (start) begin
          pc_d      = '0;
          retired_d = '0;
          state_d   = ST_FETCH;
        end
      end
`ifdef SEQ_WATCHDOG_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    run_d = (state_d == ST_EXEC);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= 16'h0000;
      retired_q <= 16'h0000;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      run_q     <= run_d;
    end
  end

  assign imem_rd_en  = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign run         = run_q;
  assign retired     = retired_q;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC);
  assign halted      = (state_q == ST_HALTED);
`ifdef SEQ_WATCHDOG_EN
  assign fault       = (state_q == ST_FAULT);
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: bench-side ROM and a minimal
// control_unit stand-in that raises done2 on the sixth run cycle.
// Watchdog checks are compiled in when SEQ_WATCHDOG_EN is defined.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        zero;
  logic        done2;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic        run;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] retired;
  logic        fault;

  logic [15:0] rom [0:255];
  logic [3:0]  run_cnt;
  logic        block_done2;
  logic        done2_extra;

  int errors = 0;
  int checks = 0;

  instruction_sequencer #(
    .ADDR_WIDTH (8),
    .WDOG_LIMIT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .zero        (zero),
    .done2       (done2),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .run         (run),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= rom[imem_addr];
  end

  // control_unit stand-in: done2 on the sixth consecutive run cycle.
  always @(posedge clk) begin
    if (reset || !run) run_cnt <= 4'd0;
    else               run_cnt <= run_cnt + 4'd1;
  end
  assign done2 = (run && (run_cnt == 4'd5) && !block_done2) || done2_extra;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; zero = 1'b0;
    block_done2 = 1'b0; done2_extra = 1'b0;
    imem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) rom[i] = 16'h001E;

    // Reset values
    cyc(); cyc();
    check("rst_pc", pc, 0);
    check("rst_instr", instruction, 16'h0000);
    check("rst_run", run, 0);
    check("rst_rd_en", imem_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    check("rst_fault", fault, 0);
    reset = 1'b0;
    cyc();

    // R-type at 0, HALT at 1
    rom[0] = 16'h1230;
    rom[1] = 16'h001E;
    pulse_start();
    check("r_fetch_rd_en", imem_rd_en, 1);
    check("r_fetch_addr", imem_addr, 0);
    check("r_fetch_busy", busy, 1);
    cyc();
    check("r_decode_run", run, 0);
    check("r_decode_rd_en", imem_rd_en, 0);
    cyc();
    n = 0;
    while (run && n < 20) begin
      n++;
      check("r_instr_stable", instruction, 16'h1230);
      cyc();
    end
    check("r_run_cycles", n, 6);
    check("r_pc_after", pc, 1);
    check("r_retired_after", retired, 1);
    check("r_refetch_rd_en", imem_rd_en, 1);
    cyc(); cyc();
    check("h1_halted", halted, 1);
    check("h1_busy", busy, 0);
    check("h1_pc", pc, 1);
    check("h1_retired", retired, 2);

    // JMP to 5, HALT at 5
    rom[0] = 16'h0502;
    rom[5] = 16'h001E;
    pulse_start();
    check("jmp_restart_pc", pc, 0);
    check("jmp_restart_retired", retired, 0);
    check("jmp_fetch_run", run, 0);
    cyc();
    check("jmp_decode_run", run, 0);
    cyc();
    check("jmp_pc", pc, 5);
    check("jmp_retired", retired, 1);
    check("jmp_run", run, 0);
    check("jmp_rd_en", imem_rd_en, 1);
    cyc(); cyc();
    check("jmp_halted", halted, 1);
    check("jmp_halt_pc", pc, 5);

    // JZ / JNZ with both zero values, then a J-type NOP and HALT
    rom[8'h00] = 16'h1006;
    rom[8'h10] = 16'h2006;
    rom[8'h11] = 16'h300A;
    rom[8'h30] = 16'h400A;
    rom[8'h31] = 16'h770E;
    rom[8'h32] = 16'h001E;
    pulse_start();
    zero = 1'b1; cyc(); cyc();
    check("jz_taken_pc", pc, 8'h10);
    zero = 1'b0; cyc(); cyc();
    check("jz_not_taken_pc", pc, 8'h11);
    zero = 1'b0; cyc(); cyc();
    check("jnz_taken_pc", pc, 8'h30);
    zero = 1'b1; cyc(); cyc();
    check("jnz_not_taken_pc", pc, 8'h31);
    zero = 1'b0; cyc(); cyc();
    check("jnop_pc", pc, 8'h32);
    check("jnop_retired", retired, 5);
    cyc(); cyc();
    check("jseq_halted", halted, 1);
    check("jseq_pc", pc, 8'h32);
    check("jseq_retired", retired, 6);

    // PC wrap at 0xFF, with start/done2 noise outside their windows
    rom[0]     = 16'hFF02;
    rom[8'hFF] = 16'hABC1;
    pulse_start();
    cyc(); cyc();
    check("wrap_jmp_pc", pc, 8'hFF);
    rom[0] = 16'h001E;
    start = 1'b1; done2_extra = 1'b1;
    cyc();
    check("ign_decode_busy", busy, 1);
    check("ign_decode_pc", pc, 8'hFF);
    check("ign_decode_run", run, 0);
    done2_extra = 1'b0;
    cyc();
    check("wrap_exec_run", run, 1);
    check("wrap_exec_instr", instruction, 16'hABC1);
    cyc();
    check("ign_exec_start_run", run, 1);
    check("ign_exec_start_pc", pc, 8'hFF);
    start = 1'b0;
    n = 0;
    while (run && n < 20) begin n++; cyc(); end
    check("wrap_run_ended", run, 0);
    check("wrap_pc", pc, 0);
    check("wrap_retired", retired, 2);
    cyc(); cyc();
    check("wrap_halted", halted, 1);
    check("wrap_halt_retired", retired, 3);

    // Reset on the done2 cycle: no pc/retire update completes
    rom[0] = 16'h5550;
    pulse_start();
    cyc(); cyc();
    n = 0;
    while (!done2 && n < 20) begin n++; cyc(); end
    check("mid_done2_seen", done2, 1);
    reset = 1'b1;
    cyc();
    check("mid_rst_pc", pc, 0);
    check("mid_rst_retired", retired, 0);
    check("mid_rst_run", run, 0);
    check("mid_rst_instr", instruction, 16'h0000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_halted", halted, 0);
    reset = 1'b0;
    cyc();

`ifdef SEQ_WATCHDOG_EN
    // Watchdog: done2 withheld, fault after 15 run cycles
    block_done2 = 1'b1;
    pulse_start();
    cyc(); cyc();
    n = 0;
    while (run && n < 40) begin n++; cyc(); end
    check("wd_run_cycles", n, 15);
    check("wd_fault", fault, 1);
    check("wd_run", run, 0);
    check("wd_busy", busy, 0);
    pulse_start();
    cyc();
    check("wd_fault_sticky", fault, 1);
    check("wd_no_fetch", imem_rd_en, 0);
    block_done2 = 1'b0;
    reset = 1'b1;
    cyc();
    check("wd_rst_fault", fault, 0);
    reset = 1'b0;
    cyc();
`else
    check("nowd_fault", fault, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
